// File: rtl/instr_fetch_unit.sv
// Instruction-fetch sequencer: holds the PC, fetches one instruction at a time
// over a req/ack handshake and presents it (with OP/FUNC) to the control unit.
// Next PC comes from the control unit's JUMP/BRANCH decision and the ALU Z flag.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] INSTR,
   output logic [5:0]  OP,
   output logic [5:0]  FUNC,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        JUMP,
   input  logic        BRANCH,
   input  logic        Z,
   output logic [31:0] PC,
   output logic [31:0] PC_PLUS4,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_ISSUE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] count_q, count_d;

   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic [31:0] next_pc;
   logic        retire;

   // Next-PC selection; JUMP outranks a taken branch.
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      next_pc  = pc_plus4;
      if (JUMP) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (BRANCH && Z) begin
         next_pc = pc_plus4 + br_off;
      end
   end

   // Sequencer: IDLE once after reset, then alternate REQ (fetch) / ISSUE (hold).
   // imem_ack only matters in REQ; decisions only matter in the retire cycle.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (instr_ready) begin
               retire  = 1'b1;
               pc_d    = next_pc;
               count_d = count_q + 32'd1;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any outstanding fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         count_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         count_q <= count_d;
      end
   end

   assign imem_req    = (state_q == S_REQ);
   assign instr_valid = (state_q == S_ISSUE);
   assign imem_addr   = pc_q;
   assign PC          = pc_q;
   assign PC_PLUS4    = pc_plus4;
   assign INSTR       = instr_q;
   assign OP          = instr_q[31:26];
   assign FUNC        = instr_q[5:0];
   assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of instructions walked through
// the fetch/issue handshake, plus hand sequences for reset and wrap cases.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] INSTR;
   logic [5:0]  OP;
   logic [5:0]  FUNC;
   logic        instr_valid;
   logic        instr_ready;
   logic        JUMP;
   logic        BRANCH;
   logic        Z;
   logic [31:0] PC;
   logic [31:0] PC_PLUS4;
   logic [31:0] instr_count;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .INSTR       (INSTR),
      .OP          (OP),
      .FUNC        (FUNC),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .JUMP        (JUMP),
      .BRANCH      (BRANCH),
      .Z           (Z),
      .PC          (PC),
      .PC_PLUS4    (PC_PLUS4),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;      // expected fetch address (checks previous next_pc)
      logic [31:0] rdata;     // instruction returned by memory
      logic        jump;
      logic        branch;
      logic        z;
      int          ack_wait;  // cycles memory delays the ack
      int          rdy_wait;  // cycles downstream holds off instr_ready
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_count;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Carry one instruction from REQ through retire.
   task automatic do_instr(input vec_t v, input bit b2b);
      int w;
      w = 0;
      while (imem_req !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("req_seen", {31'h0, imem_req}, 32'h1);
      if (imem_req !== 1'b1) return;
      if (b2b) chk("b2b_req_wait", w, 32'h0);
      chk("req_addr", imem_addr, v.addr);
      chk("req_valid_low", {31'h0, instr_valid}, 32'h0);
      for (int i = 0; i < v.ack_wait; i++) begin
         @(negedge clk);
         chk("stall_req", {31'h0, imem_req}, 32'h1);
         chk("stall_addr", imem_addr, v.addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      chk("issue_valid", {31'h0, instr_valid}, 32'h1);
      chk("issue_req_low", {31'h0, imem_req}, 32'h0);
      chk("instr", INSTR, v.rdata);
      chk("op", {26'h0, OP}, {26'h0, v.rdata[31:26]});
      chk("func", {26'h0, FUNC}, {26'h0, v.rdata[5:0]});
      chk("pc", PC, v.addr);
      chk("pc_plus4", PC_PLUS4, v.addr + 32'd4);
      // Hold off: decisions and a spurious ack must not disturb anything.
      for (int i = 0; i < v.rdy_wait; i++) begin
         instr_ready = 1'b0;
         JUMP = 1'b1; BRANCH = 1'b1; Z = 1'b1;
         imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         chk("hold_instr", INSTR, v.rdata);
         chk("hold_pc", PC, v.addr);
         chk("hold_count", instr_count, exp_count);
         chk("hold_valid", {31'h0, instr_valid}, 32'h1);
      end
      imem_ack = 1'b0; imem_rdata = 32'h0;
      instr_ready = 1'b1;
      JUMP = v.jump; BRANCH = v.branch; Z = v.z;
      @(negedge clk);
      instr_ready = 1'b0;
      JUMP = 1'b0; BRANCH = 1'b0; Z = 1'b0;
      exp_count = exp_count + 32'd1;
      chk("count", instr_count, exp_count);
      chk("post_retire_valid", {31'h0, instr_valid}, 32'h0);
   endtask

   initial begin
      // addr, rdata, J, B, Z, ack_wait, rdy_wait
      vecs[0]  = '{32'h0000_0000, 32'h0000_0020, 0, 0, 0, 0, 0};
      vecs[1]  = '{32'h0000_0004, 32'h2000_0001, 0, 0, 0, 3, 0};
      vecs[2]  = '{32'h0000_0008, 32'h0000_0022, 0, 0, 0, 0, 0};
      vecs[3]  = '{32'h0000_000C, 32'h0800_0040, 1, 0, 0, 0, 0};  // jump -> 0x100
      vecs[4]  = '{32'h0000_0100, 32'h0800_0010, 1, 0, 0, 0, 5};  // jump -> 0x40
      vecs[5]  = '{32'h0000_0040, 32'h1000_FFF7, 0, 1, 1, 0, 0};  // br -9 -> 0x20
      vecs[6]  = '{32'h0000_0020, 32'h1000_FFFF, 0, 1, 0, 0, 0};  // not taken -> 0x24
      vecs[7]  = '{32'h0000_0024, 32'h1000_FFFE, 0, 1, 1, 0, 0};  // br -2 -> 0x20
      vecs[8]  = '{32'h0000_0020, 32'h1000_FFFF, 0, 1, 1, 0, 0};  // br -1 -> 0x20
      vecs[9]  = '{32'h0000_0020, 32'h0800_FFFF, 1, 1, 1, 0, 0};  // jump wins -> 0x3FFFC
      vecs[10] = '{32'h0003_FFFC, 32'h0800_0000, 1, 0, 0, 0, 0};  // jump -> 0
      vecs[11] = '{32'h0000_0000, 32'h1000_FFFE, 0, 1, 1, 0, 0};  // br -2 -> FFFF_FFFC
      vecs[12] = '{32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 0, 0, 0};  // wraps -> 0
      vecs[13] = '{32'h0000_0000, 32'h1000_FFFD, 0, 1, 1, 0, 0};  // br -3 -> FFFF_FFF8
      vecs[14] = '{32'hFFFF_FFF8, 32'h1000_0001, 0, 1, 1, 0, 0};  // br +1 -> 0
      vecs[15] = '{32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 0};  // -> 4

      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      JUMP = 1'b0; BRANCH = 1'b0; Z = 1'b0;
      exp_count = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", INSTR, 32'h0);
      chk("rst_op_func", {20'h0, OP, FUNC}, 32'h0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_pc_plus4", PC_PLUS4, 32'h4);
      chk("rst_count", instr_count, 32'h0);
      rst = 1'b0;
      chk("idle_req", {31'h0, imem_req}, 32'h0);
      @(negedge clk);
      chk("first_req", {31'h0, imem_req}, 32'h1);

      for (int i = 0; i < NV; i++) begin
         do_instr(vecs[i], i > 0);
         if (i == 2) chk("count_after_3", instr_count, 32'd3);
      end
      chk("final_req", {31'h0, imem_req}, 32'h1);
      chk("final_addr", imem_addr, 32'h0000_0004);

      // Reset while a fetch is outstanding, then a stale ack lands in IDLE.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_count = 32'h0;
      chk("mrst_req", {31'h0, imem_req}, 32'h0);
      chk("mrst_valid", {31'h0, instr_valid}, 32'h0);
      chk("mrst_instr", INSTR, 32'h0);
      chk("mrst_count", instr_count, 32'h0);
      chk("mrst_pc", PC, 32'h0);
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 32'h0;
      chk("stale_req", {31'h0, imem_req}, 32'h1);
      chk("stale_addr", imem_addr, 32'h0);
      chk("stale_instr", INSTR, 32'h0);
      chk("stale_valid", {31'h0, instr_valid}, 32'h0);
      do_instr('{32'h0000_0000, 32'h0000_0024, 0, 0, 0, 1, 1}, 1'b1);
      chk("restart_next_addr", imem_addr, 32'h0000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch sequencer on the producing side of the control-unit interface. It holds the PC, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents each instruction with its OP/FUNC fields to the combinational control unit. It consumes the returned JUMP, BRANCH and Z decisions to compute the next PC. One instruction is in flight at a time; there is no pipelining.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset; synchronous, active-high.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals PC and is always word aligned.
imem_ack  input  1  memory has returned data on imem_rdata this cycle.
imem_rdata  input  32  instruction word; valid only when imem_ack=1.
INSTR  output  32  held instruction.
OP  output  6  INSTR[31:26], driven to the control unit op input.
FUNC  output  6  INSTR[5:0], driven to the control unit func input.
instr_valid  output  1  INSTR/OP/FUNC are valid for consumption.
instr_ready  input  1  downstream accepts the instruction this cycle.
JUMP  input  1  from control unit.
BRANCH  input  1  from control unit.
Z  input  1  ALU zero flag for the current instruction.
PC  output  32  address of the held instruction.
PC_PLUS4  output  32  PC+4, modulo 2^32.
instr_count  output  32  number of retired instructions; wraps modulo 2^32.

Behaviour:
- Reset values: state=IDLE, PC=RESET_PC, INSTR=0 (OP=0, FUNC=0, which decodes as nop), imem_req=0, instr_valid=0, instr_count=0.
- rst has priority over every other input in the same cycle. Reset in any state abandons the outstanding fetch. imem_ack is ignored whenever imem_req=0.
- State machine (registered state; imem_req and instr_valid are decoded from state):
  - IDLE: imem_req=0. Moves to REQ on the next cycle. Occupied only for the first cycle after reset.
  - REQ: imem_req=1 and imem_addr=PC. Both stay stable until imem_ack. On imem_ack (the same-cycle ack is legal), INSTR<=imem_rdata and the state moves to ISSUE.
  - ISSUE: instr_valid=1. INSTR, PC and PC_PLUS4 stay stable while instr_ready=0; the wait is unbounded. On instr_valid&instr_ready (retire):
    - instr_count increments.
    - PC<=next_pc.
    - State moves to REQ.
- next_pc is evaluated in the retire cycle from the held INSTR and the same-cycle JUMP/BRANCH/Z:
  - JUMP=1: {PC_PLUS4[31:28], INSTR[25:0], 2'b00}. JUMP has priority over BRANCH.
  - Otherwise, BRANCH=1 and Z=1: PC_PLUS4 + ({{14{INSTR[15]}}, INSTR[15:0], 2'b00}), modulo 2^32.
  - Otherwise: PC_PLUS4.
- Throughput: with zero-wait memory and instr_ready held at 1, one instruction retires every 2 cycles (REQ, ISSUE).
- Wrap-around: PC 32'hFFFF_FFFC sequences to 32'h0000_0000 with no error.
- JUMP, BRANCH and Z are ignored outside the retire cycle.

Test Plan:
- Reset, sequential fetch: RESET_PC=0, memory acks in the same cycle, instr_ready=1, JUMP=BRANCH=0 -> imem_addr=0x0,0x4,0x8 on successive REQ cycles; instr_valid pulses every 2nd cycle; instr_count=3 after the third retire.
- Jump: PC=0x100, INSTR=0x0800_0010, JUMP=1 at retire -> next imem_addr=0x0000_0040; OP=6'b000010.
- Branch: PC=0x20, INSTR[15:0]=0xFFFF, BRANCH=1. With Z=1 -> next PC=0x20. With Z=0 -> next PC=0x24. With JUMP=BRANCH=Z=1 -> the jump target is taken.
- Stalls: ack delayed 3 cycles -> imem_req=1 and imem_addr stable for 4 cycles. instr_ready low for 5 cycles -> INSTR/PC unchanged and instr_count unchanged. A spurious ack while in ISSUE is ignored.
- Reset mid-operation: assert rst in REQ while awaiting ack, then ack arrives after rst is deasserted -> fetch restarts at RESET_PC; the stale ack in IDLE is ignored; INSTR=0 and instr_count=0 after reset.
- Wrap: PC=0xFFFF_FFFC, no jump/branch -> next imem_addr=0x0000_0000. Branch at PC=0xFFFF_FFF8 with offset +1 -> PC=0x0000_0000.
